// File: rtl/latch_bank_writer_if.sv
// Request-side bus of latch_bank_writer: write/clear requests in, status out.
interface latch_bank_writer_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          clr_req;
  logic          busy;
  logic          done;
  logic          wr_err;

  modport master (
    output req_valid, req_addr, req_data, clr_req,
    input  req_ready, busy, done, wr_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_req,
    output req_ready, busy, done, wr_err
  );
endinterface

// File: rtl/latch_bank_writer.sv
// Write-side sequencer for a bank of D latches: setup, one-hot enable pulse, hold; plus bulk clear.
// Optional readback check of lat_q is enabled by defining LATCH_WR_READBACK_EN.
module latch_bank_writer #(
  parameter int DW        = 8,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  latch_bank_writer_if.slave   bus,
  output logic [DW-1:0]        lat_d,
  output logic [(1<<AW)-1:0]   lat_en,
  output logic                 lat_rst
`ifdef LATCH_WR_READBACK_EN
  ,
  input  logic [DW-1:0]        lat_q
`endif
);
  localparam int NL   = 1 << AW;
  localparam int MAX1 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC = (MAX1 > HOLD_CYC) ? MAX1 : HOLD_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  generate
    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
      $error("latch_bank_writer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CLR, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] addr_q;
  logic          last, accept;
  logic [NL-1:0] en_nx;
  logic          rst_nx, done_nx, done_q;

  assign last   = (cnt == '0);
  assign accept = (state == IDLE) && !bus.clr_req && bus.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Phase counter counts down to zero and is reloaded whenever a new state is entered.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.clr_req) state_nx = CLR;
               else if (bus.req_valid) state_nx = SETUP;
      SETUP:   if (last) state_nx = PULSE;
      PULSE:   if (last) state_nx = HOLD;
      HOLD:    if (last) state_nx = DONE;
      CLR:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    cnt_nx = cnt;
    if (state_nx != state) begin
      case (state_nx)
        SETUP:   cnt_nx = CW'(SETUP_CYC - 1);
        PULSE:   cnt_nx = CW'(PULSE_CYC - 1);
        HOLD:    cnt_nx = CW'(HOLD_CYC - 1);
        CLR:     cnt_nx = CW'(PULSE_CYC - 1);
        default: cnt_nx = '0;
      endcase
    end else if (!last) begin
      cnt_nx = cnt - CW'(1);
    end
  end

  // Strobes are decoded from the next state and registered so they are glitch-free.
  always_comb begin
    en_nx = '0;
    if (state_nx == PULSE) en_nx[addr_q] = 1'b1;
    rst_nx  = (state_nx == CLR);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_en  <= '0;
      lat_rst <= 1'b0;
      done_q  <= 1'b0;
      lat_d   <= '0;
    end else begin
      lat_en  <= en_nx;
      lat_rst <= rst_nx;
      done_q  <= done_nx;
      if (accept) lat_d <= bus.req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_q <= bus.req_addr;
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

`ifdef LATCH_WR_READBACK_EN
  logic err_nx, err_q;

  // lat_d still holds the written word on the final HOLD cycle; a clear must read back zero.
  always_comb begin
    err_nx = 1'b0;
    if (state == HOLD && last)     err_nx = (lat_q != lat_d);
    else if (state == CLR && last) err_nx = (lat_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_nx;
  end

  assign bus.wr_err = err_q;
`else
  assign bus.wr_err = 1'b0;
`endif
endmodule

// File: tb/tb_latch_bank_writer.sv
// Bench for latch_bank_writer: directed table, hand sequences and random transactions against a latch-array model.
module tb_latch_bank_writer;
  localparam int DW = 8, AW = 2, NL = 4, S = 1, P = 2, H = 1;
`ifdef LATCH_WR_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  latch_bank_writer_if #(.DW(DW), .AW(AW)) bus();
  logic [DW-1:0] lat_d;
  logic [NL-1:0] lat_en;
  logic          lat_rst;

  logic [DW-1:0] lat_arr [NL];
  logic [DW-1:0] ref_mem [NL];

`ifdef LATCH_WR_READBACK_EN
  logic [DW-1:0] lat_q;
  logic [AW-1:0] q_sel = '0;
  bit            bad_rb = 1'b0;
  assign lat_q = bad_rb ? '0 : lat_arr[q_sel];
`endif

  latch_bank_writer #(.DW(DW), .AW(AW), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .lat_d(lat_d), .lat_en(lat_en), .lat_rst(lat_rst)
`ifdef LATCH_WR_READBACK_EN
    , .lat_q(lat_q)
`endif
  );

  // Physical latch array, driven only by the DUT's latch-side outputs.
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (lat_rst)        lat_arr[i] <= '0;
      else if (lat_en[i]) lat_arr[i] <= lat_d;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            clr;
    bit            valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            bad;
    logic [NL-1:0] exp_en;
    int            exp_en_cyc;
    int            exp_rst_cyc;
    int            exp_done;
    bit            exp_err;
  } vec_t;

  function automatic vec_t mkvec(input bit clr, input bit valid, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input bit bad);
    vec_t v;
    v.clr = clr; v.valid = valid; v.addr = addr; v.data = data; v.bad = bad;
    v.exp_en      = clr ? '0 : NL'(1) << addr;
    v.exp_en_cyc  = clr ? 0 : P;
    v.exp_rst_cyc = clr ? P : 0;
    v.exp_done    = clr ? P + 1 : S + P + H + 1;
    v.exp_err     = RB && !clr && bad && (data != '0);
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic [DW-1:0] d_before;
    int en_cnt = 0, en_wrong = 0, en_first = 0, rst_cnt = 0, overlap = 0, d_wrong = 0;
    int done_cyc = 0, done_cnt = 0, ready_cyc = 0;
    bit err = 1'b0;
    @(negedge clk);
    bus.req_valid = v.valid; bus.clr_req = v.clr; bus.req_addr = v.addr; bus.req_data = v.data;
`ifdef LATCH_WR_READBACK_EN
    bad_rb = v.bad; q_sel = v.addr;
`endif
    d_before = lat_d;
    check({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.clr_req = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 25; k++) begin
      if (lat_en != '0) begin
        en_cnt++;
        if (en_first == 0) en_first = k;
        if (lat_en != v.exp_en) en_wrong++;
      end
      if (lat_rst) begin
        rst_cnt++;
        if (lat_en != '0) overlap++;
      end
      if (!v.clr && k <= S + P + H && lat_d != v.data) d_wrong++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = k; err = bus.wr_err; end
      end
      if (bus.req_ready) begin ready_cyc = k; break; end
      @(negedge clk);
    end
    check({tag, "_en_cycles"}, 32'(en_cnt), 32'(v.exp_en_cyc));
    check({tag, "_en_onehot"}, 32'(en_wrong), 32'd0);
    check({tag, "_en_first"}, 32'(en_first), v.clr ? 32'd0 : 32'(S + 1));
    check({tag, "_rst_cycles"}, 32'(rst_cnt), 32'(v.exp_rst_cyc));
    check({tag, "_en_rst_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_d_stable"}, 32'(d_wrong), 32'd0);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_ready_cycle"}, 32'(ready_cyc), 32'(v.exp_done + 1));
    check({tag, "_wr_err"}, 32'(err), 32'(v.exp_err));
    check({tag, "_d_after"}, 32'(lat_d), v.clr ? 32'(d_before) : 32'(v.data));
    if (v.clr) for (int i = 0; i < NL; i++) ref_mem[i] = '0;
    else if (v.valid) ref_mem[v.addr] = v.data;
    for (int i = 0; i < NL; i++) check($sformatf("%s_mem%0d", tag, i), 32'(lat_arr[i]), 32'(ref_mem[i]));
`ifdef LATCH_WR_READBACK_EN
    bad_rb = 1'b0;
`endif
  endtask

  vec_t tbl [8];

  initial begin
    int acc [2];
    int n, multi, seen_done, rdy;
    tbl[0] = mkvec(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    tbl[1] = mkvec(1'b0, 1'b1, 2'd2, 8'hA5, 1'b0);
    tbl[2] = mkvec(1'b1, 1'b1, 2'd1, 8'h77, 1'b0);
    tbl[3] = mkvec(1'b0, 1'b1, 2'd3, 8'hFF, 1'b0);
    tbl[4] = mkvec(1'b0, 1'b1, 2'd0, 8'h5C, 1'b0);
    tbl[5] = mkvec(1'b0, 1'b1, 2'd1, 8'h3C, 1'b1);
    tbl[6] = mkvec(1'b0, 1'b1, 2'd1, 8'h3C, 1'b0);
    tbl[7] = mkvec(1'b0, 1'b1, 2'd2, 8'h01, 1'b0);
    for (int i = 0; i < NL; i++) ref_mem[i] = '0;

    bus.req_valid = 1'b1; bus.clr_req = 1'b0; bus.req_addr = 2'd2; bus.req_data = 8'hEE;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lat_en", 32'(lat_en), 32'd0);
    check("rst_lat_rst", 32'(lat_rst), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_lat_d", 32'(lat_d), 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back: valid held high across two writes.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 2'd0; bus.req_data = 8'h11;
    n = 0; multi = 0; acc[0] = 0; acc[1] = 0;
    for (int cyc = 0; cyc < 30 && n < 2; cyc++) begin
      if ($countones(lat_en) > 1) multi++;
      if (bus.req_ready && bus.req_valid) begin acc[n] = cyc; n++; end
      @(negedge clk);
      if (n == 1) begin bus.req_addr = 2'd3; bus.req_data = 8'h22; end
    end
    bus.req_valid = 1'b0;
    rdy = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if ($countones(lat_en) > 1) multi++;
      if (bus.req_ready) begin rdy = 1; break; end
      @(negedge clk);
    end
    check("b2b_accepts", 32'(n), 32'd2);
    check("b2b_spacing", 32'(acc[1] - acc[0]), 32'(S + P + H + 2));
    check("b2b_onehot", 32'(multi), 32'd0);
    check("b2b_finish", 32'(rdy), 32'd1);
    ref_mem[0] = 8'h11; ref_mem[3] = 8'h22;
    check("b2b_mem0", 32'(lat_arr[0]), 32'h11);
    check("b2b_mem3", 32'(lat_arr[3]), 32'h22);

    // Reset while the enable pulse is high.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 2'd1; bus.req_data = 8'h5A;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rdy = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (lat_en != '0) begin rdy = 1; break; end
      @(negedge clk);
    end
    check("midop_reached_pulse", 32'(lat_en), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("midop_en_drop", 32'(lat_en), 32'd0);
    check("midop_rst_low", 32'(lat_rst), 32'd0);
    check("midop_ready", 32'(bus.req_ready), 32'd1);
    seen_done = 0;
    repeat (3) begin @(negedge clk); if (bus.done) seen_done++; end
    check("midop_no_done", 32'(seen_done), 32'd0);
    rst_n = 1'b1;
    run_txn(mkvec(1'b0, 1'b1, 2'd1, 8'hC3, 1'b0), "after_rst");

    for (int i = 0; i < 40; i++) begin
      bit c, vl;
      c  = ($urandom_range(0, 5) == 0);
      vl = c ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(mkvec(c, vl, AW'($urandom_range(0, NL - 1)), DW'($urandom), ($urandom_range(0, 3) == 0)),
              $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
